// File: rtl/gpu_bank_arbiter.sv
// Arbitrates per-warp reads and buffered writes onto one single-ported register bank.
// Reads win by default; writes are forced by starvation, a full buffer or a RAW interlock.
module gpu_bank_arbiter #(
  parameter int NUM_WARPS       = 4,
  parameter int WARP_ID_W       = 2,
  parameter int REG_ADDR_W      = 6,
  parameter int DATA_W          = 64,
  parameter int WR_FIFO_DEPTH   = 4,
  parameter int WR_STARVE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WARPS-1:0]             rd_req,
  input  logic [NUM_WARPS*REG_ADDR_W-1:0]  rd_reg,
  output logic [NUM_WARPS-1:0]             rd_gnt,
  input  logic [NUM_WARPS-1:0]             wr_valid,
  input  logic [NUM_WARPS*REG_ADDR_W-1:0]  wr_reg,
  input  logic [NUM_WARPS*DATA_W-1:0]      wr_data,
  output logic [NUM_WARPS-1:0]             wr_ready,
  output logic                             bank_read,
  output logic                             bank_write,
  output logic [REG_ADDR_W-1:0]            bank_reg,
  output logic [WARP_ID_W-1:0]             bank_warp,
  output logic [DATA_W-1:0]                bank_wdata,
  input  logic [DATA_W-1:0]                bank_rdata,
  output logic                             rd_data_valid,
  output logic [DATA_W-1:0]                rd_data,
  output logic [WARP_ID_W-1:0]             rd_data_warp,
  output logic [$clog2(WR_FIFO_DEPTH):0]   wr_fifo_count
);

  localparam int PTR_W    = $clog2(WR_FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(WR_STARVE_LIMIT + 1);
  localparam logic [WARP_ID_W-1:0] LAST_WARP  = WARP_ID_W'(NUM_WARPS - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT   = CNT_W'(WR_FIFO_DEPTH);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(WR_STARVE_LIMIT);
  localparam logic [NUM_WARPS-1:0] ONE_HOT0   = NUM_WARPS'(1);

  logic [REG_ADDR_W-1:0] rd_reg_a  [NUM_WARPS];
  logic [REG_ADDR_W-1:0] wr_reg_a  [NUM_WARPS];
  logic [DATA_W-1:0]     wr_data_a [NUM_WARPS];

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_unpack
    assign rd_reg_a[g]  = rd_reg[g*REG_ADDR_W +: REG_ADDR_W];
    assign wr_reg_a[g]  = wr_reg[g*REG_ADDR_W +: REG_ADDR_W];
    assign wr_data_a[g] = wr_data[g*DATA_W +: DATA_W];
  end

  logic [WARP_ID_W-1:0]     rd_ptr, wr_ptr;
  logic [PTR_W-1:0]         head, tail;
  logic [CNT_W-1:0]         count;
  logic [WR_FIFO_DEPTH-1:0] fifo_vld;
  logic [WARP_ID_W-1:0]     fifo_warp [WR_FIFO_DEPTH];
  logic [REG_ADDR_W-1:0]    fifo_reg  [WR_FIFO_DEPTH];
  logic [DATA_W-1:0]        fifo_data [WR_FIFO_DEPTH];
  logic [STARVE_W-1:0]      starve_cnt;
  logic                     rd_pend;
  logic [WARP_ID_W-1:0]     rd_pend_warp;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [WARP_ID_W:0] rr_pick(input logic [NUM_WARPS-1:0] req,
                                                 input logic [WARP_ID_W-1:0] ptr);
    logic [WARP_ID_W:0]   res;
    logic [WARP_ID_W-1:0] idx;
    res = '0;
    idx = ptr;
    for (int k = 0; k < NUM_WARPS; k++) begin
      if (!res[WARP_ID_W] && req[idx]) res = {1'b1, idx};
      idx = (idx == LAST_WARP) ? '0 : idx + 1'b1;
    end
    return res;
  endfunction

  function automatic logic [WARP_ID_W-1:0] next_warp(input logic [WARP_ID_W-1:0] w);
    return (w == LAST_WARP) ? '0 : w + 1'b1;
  endfunction

  logic                 fifo_nonempty, fifo_full;
  logic [WARP_ID_W:0]   wr_pick, rd_pick;
  logic                 push, issue_write, issue_read;
  logic [WARP_ID_W-1:0] push_warp, rd_win;
  logic [NUM_WARPS-1:0] hazard, eligible;

  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == FULL_CNT);

  // A full buffer always forces a pop this cycle, so a push always fits.
  always_comb begin
    wr_pick   = rr_pick(wr_valid, wr_ptr);
    push      = wr_pick[WARP_ID_W] && !rst;
    push_warp = wr_pick[WARP_ID_W-1:0];
  end

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      for (int e = 0; e < WR_FIFO_DEPTH; e++) begin
        if (fifo_vld[e] && fifo_warp[e] == WARP_ID_W'(i) && fifo_reg[e] == rd_reg_a[i])
          hazard[i] = 1'b1;
      end
      if (push && push_warp == WARP_ID_W'(i) && wr_reg_a[i] == rd_reg_a[i])
        hazard[i] = 1'b1;
    end
  end

  assign eligible = rd_req & ~hazard;

  always_comb begin
    rd_pick     = rr_pick(eligible, rd_ptr);
    rd_win      = rd_pick[WARP_ID_W-1:0];
    issue_write = !rst && fifo_nonempty &&
                  (!rd_pick[WARP_ID_W] || starve_cnt >= STARVE_MAX || fifo_full ||
                   |(rd_req & hazard));
    issue_read  = !rst && !issue_write && rd_pick[WARP_ID_W];
  end

  assign rd_gnt        = issue_read ? (ONE_HOT0 << rd_win) : '0;
  assign wr_ready      = push ? (ONE_HOT0 << push_warp) : '0;
  assign wr_fifo_count = count;

  // Pop is applied before push so a simultaneous push at full keeps its slot valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fifo_vld   <= '0;
      starve_cnt <= '0;
    end else begin
      if (issue_write) begin
        fifo_vld[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (push) begin
        fifo_vld[tail] <= 1'b1;
        tail           <= tail + 1'b1;
        wr_ptr         <= next_warp(push_warp);
      end
      count <= count + CNT_W'(push) - CNT_W'(issue_write);
      if (issue_read) rd_ptr <= next_warp(rd_win);
      if (!fifo_nonempty || issue_write)
        starve_cnt <= '0;
      else if (issue_read && starve_cnt < STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_warp[tail] <= push_warp;
      fifo_reg[tail]  <= wr_reg_a[push_warp];
      fifo_data[tail] <= wr_data_a[push_warp];
    end
  end

  // Bank command stage followed by a two-stage read return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_read     <= 1'b0;
      bank_write    <= 1'b0;
      bank_reg      <= '0;
      bank_warp     <= '0;
      bank_wdata    <= '0;
      rd_pend       <= 1'b0;
      rd_pend_warp  <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      rd_data_warp  <= '0;
    end else begin
      bank_read  <= issue_read;
      bank_write <= issue_write;
      if (issue_read) begin
        bank_reg  <= rd_reg_a[rd_win];
        bank_warp <= rd_win;
      end else if (issue_write) begin
        bank_reg   <= fifo_reg[head];
        bank_warp  <= fifo_warp[head];
        bank_wdata <= fifo_data[head];
      end
      rd_pend       <= bank_read;
      rd_pend_warp  <= bank_warp;
      rd_data_valid <= rd_pend;
      if (rd_pend) begin
        rd_data      <= bank_rdata;
        rd_data_warp <= rd_pend_warp;
      end
    end
  end

endmodule

// File: tb/tb_gpu_bank_arbiter.sv
// Directed self-checking bench for gpu_bank_arbiter with a simple per-warp register bank model.
module tb_gpu_bank_arbiter;

  localparam int NW = 4;
  localparam int RW = 6;
  localparam int DW = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NW-1:0]  rd_req;
  logic [NW*RW-1:0] rd_reg;
  logic [NW-1:0]  rd_gnt;
  logic [NW-1:0]  wr_valid;
  logic [NW*RW-1:0] wr_reg;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]  wr_ready;
  logic           bank_read, bank_write;
  logic [RW-1:0]  bank_reg;
  logic [1:0]     bank_warp;
  logic [DW-1:0]  bank_wdata;
  logic [DW-1:0]  bank_rdata;
  logic           rd_data_valid;
  logic [DW-1:0]  rd_data;
  logic [1:0]     rd_data_warp;
  logic [2:0]     wr_fifo_count;

  int num_checks = 0;
  int num_fails  = 0;

  gpu_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_reg(rd_reg), .rd_gnt(rd_gnt),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .wr_ready(wr_ready),
    .bank_read(bank_read), .bank_write(bank_write), .bank_reg(bank_reg),
    .bank_warp(bank_warp), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_warp(rd_data_warp),
    .wr_fifo_count(wr_fifo_count)
  );

  always #5 clk = ~clk;

  // Bank model: location {warp,reg} starts at 0x1000 + {warp,reg}; read data one cycle after strobe.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= 64'h1000 + 64'(a);
      bank_rdata <= '0;
    end else begin
      if (bank_write) mem[{bank_warp, bank_reg}] <= bank_wdata;
      if (bank_read)  bank_rdata <= mem[{bank_warp, bank_reg}];
    end
  end

  function automatic logic [63:0] init_val(input int w, input int r);
    return 64'h1000 + 64'(w * 64 + r);
  endfunction

  function automatic logic [63:0] onehot(input int n);
    return 64'(1) << n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NW-1:0] rq, input logic [NW-1:0] wv);
    @(negedge clk);
    rd_req   = rq;
    wr_valid = wv;
    #1;
  endtask

  logic [NW-1:0] remaining;
  int            valid_seen;

  initial begin
    rst = 1'b1; rd_req = '0; wr_valid = '0;
    rd_reg = {6'd4, 6'd3, 6'd2, 6'd1};
    wr_reg = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("reset_bank_read", 64'(bank_read), 64'(0));
    checkOutput("reset_bank_write", 64'(bank_write), 64'(0));
    checkOutput("reset_rd_valid", 64'(rd_data_valid), 64'(0));
    checkOutput("reset_fifo_count", 64'(wr_fifo_count), 64'(0));
    checkOutput("reset_rd_gnt", 64'(rd_gnt), 64'(0));
    rst = 1'b0;

    $display("[TB] round-robin reads");
    remaining = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      logic [NW-1:0] exp_gnt;
      applyStimulus(remaining, 4'b0000);
      exp_gnt = (c < 4) ? NW'(onehot(c)) : '0;
      checkOutput("rr_gnt", 64'(rd_gnt), 64'(exp_gnt));
      checkOutput("rr_bank_read", 64'(bank_read), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) checkOutput("rr_bank_warp", 64'(bank_warp), 64'(c - 1));
      checkOutput("rr_valid", 64'(rd_data_valid), 64'(c >= 3));
      if (c >= 3) begin
        checkOutput("rr_data_warp", 64'(rd_data_warp), 64'(c - 3));
        checkOutput("rr_data", rd_data, init_val(c - 3, c - 2));
      end
      remaining &= ~exp_gnt;
    end

    $display("[TB] RAW hazard");
    rd_reg[2*RW +: RW]  = 6'd5;
    wr_reg[2*RW +: RW]  = 6'd5;
    wr_data[2*DW +: DW] = 64'hDEAD;
    applyStimulus(4'b0100, 4'b0100);
    checkOutput("raw_wr_ready", 64'(wr_ready), 64'(4'b0100));
    checkOutput("raw_gnt_c0", 64'(rd_gnt), 64'(0));
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("raw_gnt_c1", 64'(rd_gnt), 64'(0));
    checkOutput("raw_count_c1", 64'(wr_fifo_count), 64'(1));
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("raw_bank_write", 64'(bank_write), 64'(1));
    checkOutput("raw_bank_reg", 64'(bank_reg), 64'(5));
    checkOutput("raw_bank_warp", 64'(bank_warp), 64'(2));
    checkOutput("raw_bank_wdata", bank_wdata, 64'hDEAD);
    checkOutput("raw_gnt_c2", 64'(rd_gnt), 64'(4'b0100));
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("raw_bank_read", 64'(bank_read), 64'(1));
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("raw_valid", 64'(rd_data_valid), 64'(1));
    checkOutput("raw_data_warp", 64'(rd_data_warp), 64'(2));
    checkOutput("raw_data", rd_data, 64'hDEAD);

    $display("[TB] non-matching read");
    rd_reg[1*RW +: RW]  = 6'd5;
    wr_data[2*DW +: DW] = 64'hBEEF;
    applyStimulus(4'b0010, 4'b0100);
    checkOutput("nm_wr_ready", 64'(wr_ready), 64'(4'b0100));
    checkOutput("nm_gnt", 64'(rd_gnt), 64'(4'b0010));
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("nm_bank_read", 64'(bank_read), 64'(1));
    checkOutput("nm_bank_warp", 64'(bank_warp), 64'(1));
    checkOutput("nm_count", 64'(wr_fifo_count), 64'(1));
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("nm_bank_write", 64'(bank_write), 64'(1));
    checkOutput("nm_bank_wdata", bank_wdata, 64'hBEEF);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("nm_valid", 64'(rd_data_valid), 64'(1));
    checkOutput("nm_data", rd_data, init_val(1, 5));

    $display("[TB] write starvation");
    rd_reg = {6'd4, 6'd3, 6'd2, 6'd1};
    wr_reg[0 +: RW]  = 6'd10;
    wr_data[0 +: DW] = 64'h5555;
    applyStimulus(4'b1111, 4'b0001);
    checkOutput("st_wr_ready", 64'(wr_ready), 64'(4'b0001));
    checkOutput("st_gnt_0", 64'(rd_gnt), onehot(2));
    for (int k = 1; k <= 10; k++) begin
      logic [63:0] exp_gnt;
      applyStimulus(4'b1111, 4'b0000);
      exp_gnt = (k < 9) ? onehot((2 + k) % 4) : (k == 9) ? 64'(0) : onehot((k + 1) % 4);
      checkOutput("st_gnt", 64'(rd_gnt), exp_gnt);
      if (k == 9) checkOutput("st_count_k9", 64'(wr_fifo_count), 64'(1));
      if (k == 10) begin
        checkOutput("st_bank_write", 64'(bank_write), 64'(1));
        checkOutput("st_bank_reg", 64'(bank_reg), 64'(10));
        checkOutput("st_bank_wdata", bank_wdata, 64'h5555);
        checkOutput("st_count_k10", 64'(wr_fifo_count), 64'(0));
      end
    end
    repeat (4) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] FIFO full");
    for (int i = 0; i < NW; i++) begin
      wr_reg[i*RW +: RW]  = RW'(20 + i);
      wr_data[i*DW +: DW] = 64'hA0 + 64'(i);
    end
    for (int c = 0; c < 7; c++) begin
      applyStimulus(4'b1111, 4'b1111);
      checkOutput("ff_wr_ready", 64'(wr_ready), onehot((1 + c) % 4));
      checkOutput("ff_gnt", 64'(rd_gnt), (c < 4) ? onehot(c) : 64'(0));
      checkOutput("ff_count", 64'(wr_fifo_count), 64'((c < 4) ? c : 4));
      if (c >= 5) begin
        checkOutput("ff_bank_write", 64'(bank_write), 64'(1));
        checkOutput("ff_bank_warp", 64'(bank_warp), 64'(c - 4));
        checkOutput("ff_bank_wdata", bank_wdata, 64'hA0 + 64'(c - 4));
      end
    end
    repeat (6) applyStimulus(4'b0000, 4'b0000);
    checkOutput("ff_drained", 64'(wr_fifo_count), 64'(0));

    $display("[TB] reset mid-traffic");
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("mr_gnt", 64'(rd_gnt), 64'(4'b0001));
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("mr_bank_read_pre", 64'(bank_read), 64'(1));
    wr_valid = 4'b1111;
    rst = 1'b1;
    #1;
    checkOutput("mr_bank_read", 64'(bank_read), 64'(0));
    checkOutput("mr_rd_gnt", 64'(rd_gnt), 64'(0));
    checkOutput("mr_wr_ready", 64'(wr_ready), 64'(0));
    checkOutput("mr_count", 64'(wr_fifo_count), 64'(0));
    checkOutput("mr_valid", 64'(rd_data_valid), 64'(0));
    @(negedge clk);
    rd_req = '0; wr_valid = '0; rst = 1'b0;
    valid_seen = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0000, 4'b0000);
      if (rd_data_valid) valid_seen++;
    end
    checkOutput("mr_no_return", 64'(valid_seen), 64'(0));
    checkOutput("mr_count_after", 64'(wr_fifo_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
